// File: rtl/fe_canon_reduce.sv
`default_nettype none
// ============================================================================
// Module   : fe_canon_reduce
// Brief    : Limb-serial canonical reduction of a 256-bit value mod 2^255-19.
// Revision : 1.0
// ============================================================================
module fe_canon_reduce #(
    parameter int LIMB_W = 32,
    parameter int NLIMB  = 256 / LIMB_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [254:0] out_data,
    output logic         busy
);

    localparam int IDX_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLIMB - 1);
    localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FOLD = 2'd1;
    localparam logic [1:0] ST_SUB  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [255:0]     w_q, w_d;
    logic [255:0]     t_q, t_d;
    logic             h_q, h_d;
    logic             pass_q, pass_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             out_valid_q, out_valid_d;
    logic [254:0]     out_data_q, out_data_d;

    logic [LIMB_W-1:0] w_limb, p_limb, w_add;
    logic [LIMB_W:0]   w_sum, w_diff;
    logic [255:0]      w_folded, w_t;

    always_comb begin
        w_limb   = w_q[idx_q*LIMB_W +: LIMB_W];
        p_limb   = P[idx_q*LIMB_W +: LIMB_W];
        w_add    = (h_q && (idx_q == '0)) ? LIMB_W'(19) : '0;
        w_sum    = {1'b0, w_limb} + {1'b0, w_add} + (LIMB_W+1)'(carry_q);
        w_diff   = {1'b0, w_limb} - {1'b0, p_limb} - (LIMB_W+1)'(carry_q);
        w_folded = w_q;
        w_folded[idx_q*LIMB_W +: LIMB_W] = w_sum[LIMB_W-1:0];
        w_t      = t_q;
        w_t[idx_q*LIMB_W +: LIMB_W] = w_diff[LIMB_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        t_d         = t_q;
        h_d         = h_q;
        pass_d      = pass_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    w_d     = {1'b0, in_data[254:0]};
                    h_d     = in_data[255];
                    pass_d  = 1'b0;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = ST_FOLD;
                end
            end
            ST_FOLD: begin
                w_d     = w_folded;
                carry_d = w_sum[LIMB_W];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Carry out of the top limb cannot occur; bit 255 is the new fold bit.
                    idx_d   = '0;
                    carry_d = 1'b0;
                    if (w_folded[255] && !pass_q) begin
                        w_d[255] = 1'b0;
                        h_d      = 1'b1;
                        pass_d   = 1'b1;
                    end else begin
                        h_d     = 1'b0;
                        state_d = ST_SUB;
                    end
                end
            end
            ST_SUB: begin
                t_d     = w_t;
                carry_d = w_diff[LIMB_W];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // w, p < 2^255, so bit 255 of w - p equals the final borrow.
                    idx_d       = '0;
                    carry_d     = 1'b0;
                    out_data_d  = w_t[255] ? w_q[254:0] : w_t[254:0];
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            w_q         <= '0;
            t_q         <= '0;
            h_q         <= 1'b0;
            pass_q      <= 1'b0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            t_q         <= t_d;
            h_q         <= h_d;
            pass_q      <= pass_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fe_canon_reduce.sv
`default_nettype none
// ============================================================================
// Module   : tb_fe_canon_reduce
// Brief    : Directed and random self-checking bench for fe_canon_reduce.
// Revision : 1.0
// ============================================================================
module tb_fe_canon_reduce;

    localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [254:0] out_data;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fe_canon_reduce #(.LIMB_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Any value < 2^256 is below 3p, so at most two subtractions are needed.
    function automatic logic [255:0] ref_mod(input logic [255:0] x);
        logic [255:0] r;
        r = x;
        for (int k = 0; k < 3; k++)
            if (r >= P) r = r - P;
        return r;
    endfunction

    task automatic do_op(input logic [255:0] d, input int lat, input int stall, input string tag);
        logic [255:0] exp;
        int n;
        exp = ref_mod(d);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
        chk({tag, "/in_ready_busy"}, {254'd0, in_ready, busy}, 256'd1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "/out_valid_seen"}, {255'd0, out_valid}, 256'd1);
        if (lat >= 0) chk({tag, "/latency"}, 256'(n), 256'(lat));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
        end
        chk({tag, "/data"}, {1'b0, out_data}, exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "/consumed"}, {254'd0, out_valid, in_ready}, 256'd1);
    endtask

    initial begin
        logic [254:0] held;
        logic [255:0] d;
        logic         bad;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {out_data, 1'b0} | 256'({in_ready, out_valid, busy}), 256'd4);
        rst = 1'b0;

        do_op(256'd0,          16, 0, "zero");
        do_op(P,               16, 0, "p");
        do_op(P + 256'd1,      16, 0, "p_plus_1");
        do_op(P - 256'd1,      16, 0, "p_minus_1");
        do_op(256'd1 << 255,   16, 0, "two_pow_255");
        do_op({256{1'b1}},     24, 0, "all_ones");
        do_op(P << 1,          16, 0, "two_p");

        // Output held in DONE while the consumer stalls; input pulses ignored.
        in_data  = 256'd123;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        chk("stall/valid", {255'd0, out_valid}, 256'd1);
        held = out_data;
        bad  = 1'b0;
        for (int s = 0; s < 10; s++) begin
            in_valid = s[0];
            in_data  = 256'd999 + 256'(s);
            @(posedge clk); #1;
            if (!out_valid || in_ready || out_data !== held) bad = 1'b1;
        end
        in_valid = 1'b0;
        chk("stall/stable", {255'd0, bad}, 256'd0);
        chk("stall/data", {1'b0, out_data}, 256'd123);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("stall/release", {254'd0, out_valid, in_ready}, 256'd1);

        // Reset during FOLD discards the operation.
        in_data  = P + 256'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset/state", 256'({in_ready, out_valid, busy}), 256'd4);
        bad = 1'b0;
        for (int s = 0; s < 30; s++) begin
            @(posedge clk); #1;
            if (out_valid) bad = 1'b1;
        end
        chk("midreset/no_stale", {255'd0, bad}, 256'd0);
        do_op(256'd5, 16, 0, "after_reset");

        for (int r = 0; r < 200; r++) begin
            d = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
            if (r % 4 == 1) d[255:8] = '1;
            if (r % 4 == 2) d[255:40] = P[255:40];
            do_op(d, -1, int'($urandom_range(0, 3)), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
